acc_seq_ctrl: RTL and testbench
===============================

ACC_SEQ_CTRL -- requirements
Module: acc_seq_ctrl

Interface
REQ-001 Parameter ADDR_W, default 6, width of the memory address bus.
REQ-002 Parameter GROUP_LOG2, default 3, log2 of words summed per group (group size G = 2**GROUP_LOG2).
REQ-003 Parameter NUM_WORDS, default 32, words read per run; SHALL be a multiple of G and not exceed 2**ADDR_W.
REQ-004 Parameter RD_LAT, default 2, cycles from first ReadEnable cycle to valid read data; SHALL be >= 1.
REQ-005 Parameter RES_BASE, default 32, address of the first group result; RES_BASE + NUM_WORDS/G SHALL not exceed 2**ADDR_W.
REQ-006 Clock  input  1  single clock, all state changes on rising edge.
REQ-007 Reset  input  1  asynchronous, active-low reset.
REQ-008 Start  input  1  run request, sampled only in IDLE.
REQ-009 Mode  input  1  0 = per-group sums (accumulator cleared between groups); 1 = running sums (no clear between groups); sampled with Start.
REQ-010 Abort  input  1  synchronous abort of a run in progress.
REQ-011 Address  output  ADDR_W  memory address.
REQ-012 ReadEnable  output  1  memory read strobe.
REQ-013 WriteEnable  output  1  memory write strobe.
REQ-014 Load  output  1  accumulator operand register load.
REQ-015 Clear  output  1  active-low accumulator clear.
REQ-016 Transfer  output  1  accumulator add/transfer strobe.
REQ-017 Busy  output  1  high in every state except IDLE.
REQ-018 Ready  output  1  one-cycle run-complete pulse.

Function
REQ-019 States SHALL be IDLE, REQ, WAIT, LOAD, ADD, SAVE, POST, DONE; outputs are decoded from current state only (Moore).
REQ-020 IDLE: Clear=0, all other strobes 0, Address=0; Start=1 -> REQ, latching Mode, read pointer=0, group index=0.
REQ-021 REQ: ReadEnable=1, Address=read pointer; -> WAIT if RD_LAT>1, else -> LOAD.
REQ-022 WAIT: ReadEnable=1, Address=read pointer, held RD_LAT-1 cycles, then -> LOAD.
REQ-023 LOAD: ReadEnable=1, Load=1, Address=read pointer; -> ADD.
REQ-024 ADD: Transfer=1, Address=0; read pointer increments; -> SAVE if word was last of its group, else -> REQ.
REQ-025 SAVE: WriteEnable=1, Address=RES_BASE+group index; -> POST.
REQ-026 POST: Clear=0 if latched Mode=0, Clear=1 if Mode=1; group index increments; -> DONE if read pointer = NUM_WORDS, else -> REQ.
REQ-027 DONE: Ready=1 for exactly one cycle, Clear=1; -> IDLE.
REQ-028 Outside listed assertions: Clear=1, ReadEnable=WriteEnable=Load=Transfer=Ready=0, Address=0.
REQ-029 Per-word cost SHALL be RD_LAT+2 cycles; per-group overhead 2 cycles; run length (first REQ to DONE inclusive) = NUM_WORDS*(RD_LAT+2) + 2*NUM_WORDS/G + 1.
REQ-030 Start while Busy=1 SHALL be ignored; Mode changes during a run SHALL have no effect.
REQ-031 Abort=1 in any Busy state except DONE SHALL force IDLE on the next edge; no SAVE, no Ready; Abort has priority over all other transitions.
REQ-032 Abort in DONE or IDLE SHALL be ignored; Abort and Start both high in IDLE -> Start wins.
REQ-033 Read pointer is ADDR_W bits and SHALL never wrap during a run; DONE is reached exactly when pointer equals NUM_WORDS.
REQ-034 Back-to-back runs: Start high in the cycle after DONE starts a new run immediately from IDLE.

Reset
REQ-035 Reset low SHALL immediately force IDLE, read pointer, group index, wait counter to 0, Mode latch to 0.
REQ-036 During and after reset: Clear=0, Address=0, all other outputs 0, Busy=0.
REQ-037 Reset mid-run SHALL discard the run; no further writes or Ready pulse.

Verification
REQ-038 Defaults, Mode=0, Start pulse -> first REQ Address=0; Ready at cycle 137; writes to 32,33,34,35 in cycles 33,67,101,135; Clear=0 in cycles 34,68,102,136.
REQ-039 Defaults, Mode=1 -> same write timing/addresses; Clear stays 1 from first REQ through DONE.
REQ-040 RD_LAT=1, GROUP_LOG2=2, NUM_WORDS=8 -> 3 cycles per word, writes at 32,33, Ready at cycle 29.
REQ-041 Abort asserted during second group's LOAD -> IDLE next cycle, Clear=0, no further WriteEnable, no Ready.
REQ-042 Start re-asserted mid-run -> no effect on Address sequence; reset pulse mid-WAIT -> Busy=0, Clear=0, Address=0 at once.

Source files
------------

// File: rtl/acc_seq_ctrl.sv
// acc_seq_ctrl: Moore sequencer that streams NUM_WORDS memory words into an
// external accumulator and writes one result per group of 2**GROUP_LOG2
// words to RES_BASE + group index.
module acc_seq_ctrl #(
    parameter int ADDR_W     = 6,
    parameter int GROUP_LOG2 = 3,
    parameter int NUM_WORDS  = 32,
    parameter int RD_LAT     = 2,
    parameter int RES_BASE   = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Mode,
    input  logic              Abort,
    output logic [ADDR_W-1:0] Address,
    output logic              ReadEnable,
    output logic              WriteEnable,
    output logic              Load,
    output logic              Clear,
    output logic              Transfer,
    output logic              Busy,
    output logic              Ready
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_LOAD = 3'd3;
    localparam logic [2:0] S_ADD  = 3'd4;
    localparam logic [2:0] S_SAVE = 3'd5;
    localparam logic [2:0] S_POST = 3'd6;
    localparam logic [2:0] S_DONE = 3'd7;

    // One extra pointer bit so a run covering the whole address space
    // still reaches NUM_WORDS instead of wrapping to zero.
    localparam int PTR_W  = ADDR_W + 1;
    localparam int WCNT_W = $clog2(RD_LAT + 1);
    localparam int GSIZE  = 1 << GROUP_LOG2;

    logic [2:0]        state_q, state_d;
    logic [PTR_W-1:0]  ptr_q;
    logic [ADDR_W-1:0] grp_q;
    logic [WCNT_W-1:0] wcnt_q;
    logic              mode_q;
    logic              last_in_group;
    logic              all_read;

    assign last_in_group = ((ptr_q + 1'b1) & PTR_W'(GSIZE - 1)) == '0;
    assign all_read      = (ptr_q == PTR_W'(NUM_WORDS));

    // Next-state selection; Abort overrides every transition of a busy run
    // except DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (Start) state_d = S_REQ;
            S_REQ:   state_d = (RD_LAT > 1) ? S_WAIT : S_LOAD;
            S_WAIT:  if (wcnt_q == '0) state_d = S_LOAD;
            S_LOAD:  state_d = S_ADD;
            S_ADD:   state_d = last_in_group ? S_SAVE : S_REQ;
            S_SAVE:  state_d = S_POST;
            S_POST:  state_d = all_read ? S_DONE : S_REQ;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (Abort && (state_q != S_IDLE) && (state_q != S_DONE)) begin
            state_d = S_IDLE;
        end
    end

    // State register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Run bookkeeping: mode latch, read pointer, group index, wait counter.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            mode_q <= 1'b0;
            ptr_q  <= '0;
            grp_q  <= '0;
            wcnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (Start) begin
                    mode_q <= Mode;
                    ptr_q  <= '0;
                    grp_q  <= '0;
                end
                S_REQ:  wcnt_q <= (RD_LAT > 1) ? WCNT_W'(RD_LAT - 2) : '0;
                S_WAIT: if (wcnt_q != '0) wcnt_q <= wcnt_q - 1'b1;
                S_ADD:  ptr_q <= ptr_q + 1'b1;
                S_POST: grp_q <= grp_q + 1'b1;
                default: ;
            endcase
        end
    end

    // Moore output decode from the current state.
    always_comb begin
        Address     = '0;
        ReadEnable  = 1'b0;
        WriteEnable = 1'b0;
        Load        = 1'b0;
        Clear       = 1'b1;
        Transfer    = 1'b0;
        Ready       = 1'b0;
        Busy        = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: Clear = 1'b0;
            S_REQ, S_WAIT: begin
                ReadEnable = 1'b1;
                Address    = ptr_q[ADDR_W-1:0];
            end
            S_LOAD: begin
                ReadEnable = 1'b1;
                Load       = 1'b1;
                Address    = ptr_q[ADDR_W-1:0];
            end
            S_ADD:  Transfer = 1'b1;
            S_SAVE: begin
                WriteEnable = 1'b1;
                Address     = ADDR_W'(RES_BASE) + grp_q;
            end
            S_POST: Clear = mode_q;
            S_DONE: Ready = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Testbench for acc_seq_ctrl: two instances (default parameters and a short
// RD_LAT=1 / G=4 / 8-word variant) share stimulus; each is checked every
// cycle against an expected output trace built from the sequencing rules.
`timescale 1ns/1ps
module tb_acc_seq_ctrl;

    typedef logic [12:0] vec_t;   // {Busy,Ready,RE,WE,Load,Clear,Transfer,Address[5:0]}
    typedef vec_t vq_t[$];

    localparam vec_t IDLE_V = 13'h0000;

    logic clk = 1'b0;
    logic Reset, Start, Mode, Abort;

    logic [5:0] Address_a, Address_b;
    logic ReadEnable_a, WriteEnable_a, Load_a, Clear_a, Transfer_a, Busy_a, Ready_a;
    logic ReadEnable_b, WriteEnable_b, Load_b, Clear_b, Transfer_b, Busy_b, Ready_b;
    vec_t va, vb;

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;
    int start_n = 0;
    int rdy_a = -1;
    int rdy_b = -1;
    vq_t qa, qb, tmp;

    always #5 clk = ~clk;

    acc_seq_ctrl dut_a (
        .Clock(clk), .Reset(Reset), .Start(Start), .Mode(Mode), .Abort(Abort),
        .Address(Address_a), .ReadEnable(ReadEnable_a), .WriteEnable(WriteEnable_a),
        .Load(Load_a), .Clear(Clear_a), .Transfer(Transfer_a), .Busy(Busy_a), .Ready(Ready_a)
    );

    acc_seq_ctrl #(.RD_LAT(1), .GROUP_LOG2(2), .NUM_WORDS(8)) dut_b (
        .Clock(clk), .Reset(Reset), .Start(Start), .Mode(Mode), .Abort(Abort),
        .Address(Address_b), .ReadEnable(ReadEnable_b), .WriteEnable(WriteEnable_b),
        .Load(Load_b), .Clear(Clear_b), .Transfer(Transfer_b), .Busy(Busy_b), .Ready(Ready_b)
    );

    assign va = {Busy_a, Ready_a, ReadEnable_a, WriteEnable_a, Load_a, Clear_a, Transfer_a, Address_a};
    assign vb = {Busy_b, Ready_b, ReadEnable_b, WriteEnable_b, Load_b, Clear_b, Transfer_b, Address_b};

    function automatic vec_t mk(input logic b, input logic r, input logic re, input logic we,
                                input logic ld, input logic cl, input logic tr, input int a);
        return {b, r, re, we, ld, cl, tr, a[5:0]};
    endfunction

    // Expected run trace, first REQ cycle through DONE.
    function automatic void gen(input int lat, input int glog, input int n, input logic m,
                                output vq_t q);
        int gsz = 1 << glog;
        int p = 0;
        q = {};
        for (int g = 0; g < n / gsz; g++) begin
            for (int w = 0; w < gsz; w++) begin
                q.push_back(mk(1, 0, 1, 0, 0, 1, 0, p));
                for (int k = 1; k < lat; k++) q.push_back(mk(1, 0, 1, 0, 0, 1, 0, p));
                q.push_back(mk(1, 0, 1, 0, 1, 1, 0, p));
                q.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0));
                p++;
            end
            q.push_back(mk(1, 0, 0, 1, 0, 1, 0, 32 + g));
            q.push_back(mk(1, 0, 0, 0, 0, m, 0, 0));
        end
        q.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0));
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, ncyc, got, exp);
        end
    endtask

    task automatic wait_to(input int target);
        while (ncyc < target) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Called at negedge+1 with the DUTs idle. abort_at: run cycle (1-based)
    // at whose end Abort is sampled; 0 = none.
    task automatic start_run(input logic m, input int abort_at, input logic ab_now);
        vq_t ta, tb;
        Start = 1'b1;
        Mode  = m;
        Abort = ab_now;
        gen(2, 3, 32, m, ta);
        gen(1, 2, 8, m, tb);
        if (abort_at > 0 && abort_at < ta.size()) while (ta.size() > abort_at) void'(ta.pop_back());
        if (abort_at > 0 && abort_at < tb.size()) while (tb.size() > abort_at) void'(tb.pop_back());
        foreach (ta[i]) qa.push_back(ta[i]);
        foreach (tb[i]) qb.push_back(tb[i]);
        start_n = ncyc;
        rdy_a = -1;
        rdy_b = -1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        Abort = 1'b0;
        Mode  = ~m;
        if (abort_at > 0) begin
            wait_to(start_n + abort_at);
            Abort = 1'b1;
            @(posedge clk);
            #1;
            Abort = 1'b0;
        end
    endtask

    initial begin
        Reset = 1'b0;
        Start = 1'b0;
        Mode  = 1'b0;
        Abort = 1'b0;

        fork
            forever begin
                vec_t ea, eb;
                @(negedge clk);
                ncyc++;
                ea = IDLE_V;
                eb = IDLE_V;
                if (qa.size() > 0) ea = qa.pop_front();
                if (qb.size() > 0) eb = qb.pop_front();
                chk("trace_a", 32'(va), 32'(ea));
                chk("trace_b", 32'(vb), 32'(eb));
                if (Ready_a) rdy_a = ncyc;
                if (Ready_b) rdy_b = ncyc;
            end
        join_none

        // Reset state.
        #2;
        chk("rst_busy", 32'(Busy_a), 0);
        chk("rst_clear", 32'(Clear_a), 0);
        chk("rst_addr", 32'(Address_a), 0);
        wait_to(3);
        Reset = 1'b1;
        wait_to(5);

        // Hand-computed pins on the model itself.
        gen(2, 3, 32, 0, tmp);
        chk("model_len_def", 32'(tmp.size()), 137);
        chk("model_first_req", 32'(tmp[0]), 32'h1480);
        chk("model_wr32", 32'(tmp[32]), 32'h12A0);
        chk("model_post_clr", 32'(tmp[33][7]), 0);
        chk("model_wr35_addr", 32'(tmp[134][5:0]), 35);
        chk("model_ready", 32'(tmp[136][11]), 1);
        gen(2, 3, 32, 1, tmp);
        chk("model_post_clr_m1", 32'(tmp[33][7]), 1);
        gen(1, 2, 8, 0, tmp);
        chk("model_len_small", 32'(tmp.size()), 29);
        chk("model_small_wr32", 32'(tmp[12]), 32'h12A0);
        chk("model_small_wr33", 32'(tmp[26]), 32'h12A1);

        // Mode 0 run with Start re-asserted and Mode toggled mid-run.
        start_run(1'b0, 0, 1'b0);
        wait_to(start_n + 10);
        Start = 1'b1;
        Mode  = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        wait_to(start_n + 138);
        chk("ready_cyc_a", 32'(rdy_a - start_n), 137);
        chk("ready_cyc_b", 32'(rdy_b - start_n), 29);

        // Back-to-back: Start in the IDLE cycle right after DONE, Mode 1.
        start_run(1'b1, 0, 1'b0);
        wait_to(start_n + 140);
        chk("ready_cyc_a_m1", 32'(rdy_a - start_n), 137);

        // Abort during the second group's first LOAD.
        start_run(1'b0, 37, 1'b0);
        wait_to(start_n + 140);
        chk("abort_no_ready", 32'(rdy_a), 32'hFFFF_FFFF);

        // Abort at cycle 29: DONE for the short instance (ignored), mid-run for the default one.
        start_run(1'b0, 29, 1'b0);
        wait_to(start_n + 40);
        chk("abort_done_ready_b", 32'(rdy_b - start_n), 29);
        chk("abort_mid_no_ready_a", 32'(rdy_a), 32'hFFFF_FFFF);

        // Start and Abort together in IDLE: Start wins.
        start_run(1'b0, 0, 1'b1);
        wait_to(start_n + 140);
        chk("start_wins_ready", 32'(rdy_a - start_n), 137);

        // Reset pulse during WAIT.
        start_run(1'b0, 0, 1'b0);
        wait_to(start_n + 6);
        Reset = 1'b0;
        qa.delete();
        qb.delete();
        #1;
        chk("midrst_busy", 32'(Busy_a), 0);
        chk("midrst_clear", 32'(Clear_a), 0);
        chk("midrst_addr", 32'(Address_a), 0);
        wait_to(start_n + 8);
        Reset = 1'b1;
        wait_to(start_n + 20);
        chk("midrst_no_ready", 32'(rdy_a), 32'hFFFF_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
